// File: rtl/max6675_emu_if.sv
// SPI pad-side signals between an external master and the MAX6675 emulator.
interface max6675_emu_if;
    logic sclk;
    logic sel;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output sel, input miso, input miso_oe);
    modport slave  (input sclk, input sel, output miso, output miso_oe);
endinterface

// File: rtl/max6675_emu.sv
// MAX6675 thermocouple converter emulator: SPI responder serving a 16-bit frame,
// with a conversion cycle that restarts on sel rise and is aborted by sel fall.
module max6675_emu #(
    parameter int unsigned CONV_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          rst,
    max6675_emu_if.slave  spi,
    input  logic [11:0]   temperature,
    input  logic          open_tc,
    output logic          frame_done,
    output logic          converting
);
    localparam int unsigned CNT_W = $clog2(CONV_CYCLES);
    localparam int unsigned RC_W  = 5;

    typedef enum logic [1:0] {S_CONVERT, S_IDLE, S_SHIFT} state_e;

    state_e             state_q, state_d;
    logic [2:0]         sclk_sync_q, sel_sync_q;
    logic [CNT_W-1:0]   conv_cnt_q, conv_cnt_d;
    logic [11:0]        snap_temp_q, snap_temp_d;
    logic               snap_open_q, snap_open_d;
    logic [15:0]        shreg_q, shreg_d;
    logic [RC_W-1:0]    rise_cnt_q, rise_cnt_d;
    logic               miso_q, miso_d;
    logic               miso_oe_q, miso_oe_d;
    logic               frame_done_q, frame_done_d;
    logic               converting_q, converting_d;
    logic [1:0]         settle_q, settle_d;
    logic               armed_q, armed_d;

    logic        sclk_rise, sclk_fall, sel_rise, sel_fall;
    logic [15:0] frame_word;

    // Index 1 is the synchronised level, index 2 its previous value.
    // A sel fall is only accepted once sel has been seen high after reset, so a
    // reset with sel held low cannot start a frame until the master reselects.
    assign sclk_rise  =  sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall  = ~sclk_sync_q[1] &  sclk_sync_q[2];
    assign sel_rise   =  sel_sync_q[1]  & ~sel_sync_q[2];
    assign sel_fall   = ~sel_sync_q[1]  &  sel_sync_q[2] & armed_q;
    assign frame_word = {1'b0, snap_temp_q, snap_open_q, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CONVERT;
            sclk_sync_q  <= 3'b000;
            sel_sync_q   <= 3'b111;
            conv_cnt_q   <= CNT_W'(CONV_CYCLES - 1);
            snap_temp_q  <= 12'd0;
            snap_open_q  <= 1'b0;
            shreg_q      <= 16'd0;
            rise_cnt_q   <= '0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            frame_done_q <= 1'b0;
            converting_q <= 1'b1;
            settle_q     <= 2'd0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= {sclk_sync_q[1:0], spi.sclk};
            sel_sync_q   <= {sel_sync_q[1:0], spi.sel};
            conv_cnt_q   <= conv_cnt_d;
            snap_temp_q  <= snap_temp_d;
            snap_open_q  <= snap_open_d;
            shreg_q      <= shreg_d;
            rise_cnt_q   <= rise_cnt_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            frame_done_q <= frame_done_d;
            converting_q <= converting_d;
            settle_q     <= settle_d;
            armed_q      <= armed_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        conv_cnt_d   = conv_cnt_q;
        snap_temp_d  = snap_temp_q;
        snap_open_d  = snap_open_q;
        shreg_d      = shreg_q;
        rise_cnt_d   = rise_cnt_q;
        miso_d       = miso_q;
        miso_oe_d    = miso_oe_q;
        frame_done_d = 1'b0;
        settle_d     = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        armed_d      = armed_q | ((settle_q == 2'd2) & sel_sync_q[1]);

        case (state_q)
            S_CONVERT: begin
                if (sel_fall) begin
                    state_d = S_SHIFT;
                end else if (conv_cnt_q == '0) begin
                    snap_temp_d = temperature;
                    snap_open_d = open_tc;
                    state_d     = S_IDLE;
                end else begin
                    conv_cnt_d = conv_cnt_q - CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (sel_fall) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // sel rise has priority over any sclk edge seen in the same cycle
                if (sel_rise) begin
                    miso_oe_d    = 1'b0;
                    miso_d       = 1'b0;
                    conv_cnt_d   = CNT_W'(CONV_CYCLES - 1);
                    frame_done_d = (rise_cnt_q == RC_W'(16));
                    state_d      = S_CONVERT;
                end else if (sclk_rise) begin
                    if (rise_cnt_q != RC_W'(16)) rise_cnt_d = rise_cnt_q + RC_W'(1);
                end else if (sclk_fall) begin
                    shreg_d = {shreg_q[14:0], 1'b0};
                    miso_d  = shreg_q[14];
                end
            end
            default: state_d = S_CONVERT;
        endcase

        if (state_q != S_SHIFT && state_d == S_SHIFT) begin
            shreg_d    = frame_word;
            miso_d     = frame_word[15];
            miso_oe_d  = 1'b1;
            rise_cnt_d = '0;
        end

        converting_d = (state_d == S_CONVERT);
    end

    assign spi.miso    = miso_q;
    assign spi.miso_oe = miso_oe_q;
    assign frame_done  = frame_done_q;
    assign converting  = converting_q;
endmodule

// File: tb/tb_max6675_emu.sv
// Self-checking bench for max6675_emu: SPI master stimulus with a frame-word reference model.
module tb_max6675_emu;
    localparam int unsigned CONV = 200;
    localparam int unsigned HALF = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] temperature;
    logic        open_tc;
    logic        frame_done;
    logic        converting;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          fd_count = 0;
    logic [15:0] model_word;

    always #5 clk = ~clk;

    max6675_emu_if spi ();

    max6675_emu #(.CONV_CYCLES(CONV)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi         (spi),
        .temperature (temperature),
        .open_tc     (open_tc),
        .frame_done  (frame_done),
        .converting  (converting)
    );

    // Each clk during which frame_done is high adds one.
    always @(negedge clk) if (frame_done === 1'b1) fd_count++;

    function automatic logic [15:0] exp_word(input logic [11:0] t, input logic o);
        return 16'(t) * 16'd8 + (o ? 16'd4 : 16'd0);
    endfunction

    task automatic wait_conv();
        repeat (CONV + 10) @(negedge clk);
        model_word = exp_word(temperature, open_tc);
        n_checks++;
        if (converting !== 1'b0) begin
            n_fail++;
            $display("FAIL conv_idle: converting=%b want 0", converting);
        end
    endtask

    task automatic read_frame(input int nbits, output logic [31:0] word, output int oe_bad);
        word   = '0;
        oe_bad = 0;
        spi.sel = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (spi.miso_oe !== 1'b1) oe_bad++;
            word = {word[30:0], spi.miso};
            spi.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi.sclk = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        spi.sel = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_read(input string name, input int nbits, input int fd_want);
        logic [31:0] w;
        int          oe_bad;
        int          fd0;
        logic [15:0] got;
        fd0 = fd_count;
        read_frame(nbits, w, oe_bad);
        got = (nbits >= 16) ? w[nbits-1 -: 16] : 16'(w[15:0]);
        n_checks++;
        if (nbits >= 16 && got !== model_word) begin
            n_fail++;
            $display("FAIL %s word: got %h want %h", name, got, model_word);
        end else if (nbits < 16 && w[7:0] !== model_word[15:8]) begin
            n_fail++;
            $display("FAIL %s short word: got %h want %h", name, w[7:0], model_word[15:8]);
        end
        n_checks++;
        if (fd_count - fd0 != fd_want) begin
            n_fail++;
            $display("FAIL %s frame_done: got %0d pulse clks want %0d", name, fd_count - fd0, fd_want);
        end
        n_checks++;
        if (oe_bad != 0 || spi.miso_oe !== 1'b0 || converting !== 1'b1) begin
            n_fail++;
            $display("FAIL %s oe/conv: oe_bad=%0d oe_after=%b conv=%b want 0,0,1",
                     name, oe_bad, spi.miso_oe, converting);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; spi.sel = 1'b1; spi.sclk = 1'b0; temperature = '0; open_tc = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({spi.miso, spi.miso_oe, frame_done, converting} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0001",
                     {spi.miso, spi.miso_oe, frame_done, converting});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (converting !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_converting: got %b want 1", converting);
        end
    endtask

    task automatic test_basic();
        temperature = 12'h0C8; open_tc = 1'b0;
        wait_conv();
        n_checks++;
        if (model_word !== 16'h0640) begin
            n_fail++;
            $display("FAIL basic_model: got %h want 0640", model_word);
        end
        check_read("basic", 16, 1);
    endtask

    task automatic test_open_flag();
        temperature = 12'h000; open_tc = 1'b1;
        wait_conv();
        check_read("open", 16, 1);
        temperature = 12'hFFF; open_tc = 1'b0;
        wait_conv();
        check_read("full_scale", 16, 1);
    endtask

    task automatic test_abort();
        temperature = 12'h0C8; open_tc = 1'b0;
        wait_conv();
        check_read("pre_abort", 16, 1);
        temperature = 12'h190;
        repeat (2) @(negedge clk);
        check_read("aborted", 16, 1);
        wait_conv();
        check_read("post_abort", 16, 1);
    endtask

    task automatic test_long_short();
        logic [31:0] w;
        int          oe_bad;
        int          fd0;
        temperature = 12'($urandom); open_tc = 1'($urandom);
        wait_conv();
        fd0 = fd_count;
        read_frame(20, w, oe_bad);
        n_checks++;
        if (w[19:4] !== model_word || w[3:0] !== 4'h0) begin
            n_fail++;
            $display("FAIL long_frame: got %h want %h0", w[19:0], model_word);
        end
        n_checks++;
        if (fd_count - fd0 != 1 || oe_bad != 0) begin
            n_fail++;
            $display("FAIL long_frame_done: got %0d pulses oe_bad=%0d want 1,0", fd_count - fd0, oe_bad);
        end
        wait_conv();
        check_read("short", 8, 0);
    endtask

    task automatic test_reset_midframe();
        int oe_seen;
        temperature = 12'($urandom); open_tc = 1'($urandom);
        wait_conv();
        spi.sel = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            spi.sclk = 1'b1; repeat (HALF) @(negedge clk);
            spi.sclk = 1'b0; repeat (HALF) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (spi.miso_oe !== 1'b0 || converting !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_midframe: oe=%b conv=%b want 0,1", spi.miso_oe, converting);
        end
        rst = 1'b0;
        oe_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (spi.miso_oe !== 1'b0) oe_seen++;
        end
        n_checks++;
        if (oe_seen != 0) begin
            n_fail++;
            $display("FAIL rst_no_restart: oe high %0d clks want 0", oe_seen);
        end
        spi.sel = 1'b1;
        wait_conv();
        check_read("after_rst", 16, 1);
    endtask

    task automatic test_sclk_idle();
        int oe_seen;
        oe_seen = 0;
        temperature = 12'($urandom); open_tc = 1'($urandom);
        for (int i = 0; i < 10; i++) begin
            spi.sclk = 1'b1; repeat (HALF) @(negedge clk);
            if (spi.miso_oe !== 1'b0) oe_seen++;
            spi.sclk = 1'b0; repeat (HALF) @(negedge clk);
            if (spi.miso_oe !== 1'b0) oe_seen++;
        end
        n_checks++;
        if (oe_seen != 0) begin
            n_fail++;
            $display("FAIL sclk_idle_oe: oe high %0d samples want 0", oe_seen);
        end
        wait_conv();
        check_read("sclk_idle", 16, 1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++) begin
            temperature = 12'($urandom); open_tc = 1'($urandom_range(1, 0));
            wait_conv();
            check_read("random", 16, 1);
        end
    endtask

    initial begin
        spi.sel = 1'b1; spi.sclk = 1'b0; rst = 1'b1;
        temperature = '0; open_tc = 1'b0; model_word = '0;
        test_reset();
        test_basic();
        test_open_flag();
        test_abort();
        test_long_short();
        test_reset_midframe();
        test_sclk_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
